// File: rtl/data_mem_requester_if.sv
// ============================================================================
//  Module      : data_mem_requester_if
//  Description : Data-memory request/ready handshake bundle.
//                master : requester side (drives requests and command)
//                slave  : memory side (drives ready pulses and read data)
//  Signals     : read_request, write_request  - level requests
//                address, block_size, write_data - memory command
//                read_ready, write_ready, write_finished - one-cycle pulses
//                read_data - right-aligned read data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_requester_if;
    logic        read_request;
    logic        write_request;
    logic [63:0] address;
    logic [1:0]  block_size;
    logic [63:0] write_data;
    logic        read_ready;
    logic        write_ready;
    logic        write_finished;
    logic [63:0] read_data;

    modport master (
        output read_request, write_request, address, block_size, write_data,
        input  read_ready, write_ready, write_finished, read_data
    );

    modport slave (
        input  read_request, write_request, address, block_size, write_data,
        output read_ready, write_ready, write_finished, read_data
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_requester.sv
// ============================================================================
//  Module      : data_mem_requester
//  Description : Initiator side of the data-memory request/ready handshake.
//                Accepts one load or store command at a time, drives the
//                memory request, waits for the memory pulses (with timeout),
//                size-extends load data and reports completion.
//  Ports       : clk, rst_n (async, active-low)
//                start_load, start_store, cmd_address, cmd_size, cmd_signed,
//                cmd_wdata                   - command from the memory stage
//                busy, done, error, load_data - status/result to the pipeline
//                mem (master modport)        - memory handshake bundle
//  Parameters  : TIMEOUT_CYCLES - wait-state cycle limit before abort (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_requester #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         start_load,
    input  wire         start_store,
    input  wire  [63:0] cmd_address,
    input  wire  [1:0]  cmd_size,
    input  wire         cmd_signed,
    input  wire  [63:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [63:0] load_data,
    data_mem_requester_if.master mem
);

    localparam int                c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_RD_WAIT        = 3'd1,
        ST_WR_WAIT_READY  = 3'd2,
        ST_WR_WAIT_FINISH = 3'd3,
        ST_GAP            = 3'd4
    } state_t;

    state_t               r_state,  w_state;
    logic [c_cnt_w-1:0]   r_cnt,    w_cnt;
    logic                 r_signed, w_signed;
    logic                 r_busy,   w_busy;
    logic                 r_done,   w_done;
    logic                 r_error,  w_error;
    logic [63:0]          r_load_data, w_load_data;
    logic                 r_rreq,   w_rreq;
    logic                 r_wreq,   w_wreq;
    logic [63:0]          r_addr,   w_addr;
    logic [1:0]           r_size,   w_size;
    logic [63:0]          r_wdata,  w_wdata;
    logic                 w_timeout;

    // Right-aligned read data narrowed to the access size, then sign- or
    // zero-extended to the full 64 bits.
    function automatic logic [63:0] extend_load(input logic [63:0] d,
                                                input logic [1:0]  sz,
                                                input logic        sg);
        logic [63:0] v;
        case (sz)
            2'd0:    v = {{56{sg & d[7]}},  d[7:0]};
            2'd1:    v = {{48{sg & d[15]}}, d[15:0]};
            2'd2:    v = {{32{sg & d[31]}}, d[31:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    assign w_timeout = (r_cnt == c_timeout);

    always_comb begin
        w_state     = r_state;
        w_cnt       = '0;
        w_signed    = r_signed;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        w_load_data = r_load_data;
        w_rreq      = r_rreq;
        w_wreq      = r_wreq;
        w_addr      = r_addr;
        w_size      = r_size;
        w_wdata     = r_wdata;

        case (r_state)
            ST_IDLE: begin
                // Load has priority; a simultaneous store is dropped.
                if (start_load) begin
                    w_addr   = cmd_address;
                    w_size   = cmd_size;
                    w_signed = cmd_signed;
                    w_rreq   = 1'b1;
                    w_state  = ST_RD_WAIT;
                end else if (start_store) begin
                    w_addr   = cmd_address;
                    w_size   = cmd_size;
                    w_wdata  = cmd_wdata;
                    w_wreq   = 1'b1;
                    w_state  = ST_WR_WAIT_READY;
                end
            end

            ST_RD_WAIT: begin
                // The expected pulse takes priority over a coincident timeout.
                if (mem.read_ready) begin
                    w_load_data = extend_load(mem.read_data, r_size, r_signed);
                    w_rreq      = 1'b0;
                    w_done      = 1'b1;
                    w_state     = ST_GAP;
                end else if (w_timeout) begin
                    w_rreq  = 1'b0;
                    w_done  = 1'b1;
                    w_error = 1'b1;
                    w_state = ST_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_WR_WAIT_READY: begin
                // write_finished is not looked at here, so an early one is
                // ignored. The counter restarts on entry to WR_WAIT_FINISH.
                if (mem.write_ready) begin
                    w_state = ST_WR_WAIT_FINISH;
                end else if (w_timeout) begin
                    w_wreq  = 1'b0;
                    w_done  = 1'b1;
                    w_error = 1'b1;
                    w_state = ST_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_WR_WAIT_FINISH: begin
                if (mem.write_finished) begin
                    w_wreq  = 1'b0;
                    w_done  = 1'b1;
                    w_state = ST_GAP;
                end else if (w_timeout) begin
                    w_wreq  = 1'b0;
                    w_done  = 1'b1;
                    w_error = 1'b1;
                    w_state = ST_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            // One cycle with both requests low so the memory always sees a
            // fresh rising edge on the next request.
            ST_GAP: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_rreq  = 1'b0;
                w_wreq  = 1'b0;
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_load_data <= '0;
            r_rreq      <= 1'b0;
            r_wreq      <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_signed    <= w_signed;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_error     <= w_error;
            r_load_data <= w_load_data;
            r_rreq      <= w_rreq;
            r_wreq      <= w_wreq;
            r_addr      <= w_addr;
            r_size      <= w_size;
            r_wdata     <= w_wdata;
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;
    assign load_data         = r_load_data;
    assign mem.read_request  = r_rreq;
    assign mem.write_request = r_wreq;
    assign mem.address       = r_addr;
    assign mem.block_size    = r_size;
    assign mem.write_data    = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_requester.sv
// ============================================================================
//  Module      : tb_data_mem_requester
//  Description : Self-checking bench for data_mem_requester. A transaction
//                model derives, from response delays and the timeout limit,
//                the per-cycle expected outputs; one compare process checks
//                them every cycle. Directed cases pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_requester;

    localparam int TO   = 8;
    localparam int T1   = TO + 1;   // edge (after request rise) where abort happens
    localparam int MAXC = 16384;
    localparam int NONE = 1000;     // response delay meaning "never arrives"

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_load, start_store, cmd_signed;
    logic [63:0] cmd_address, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        busy, done, error;
    logic [63:0] load_data;

    data_mem_requester_if mem_bus();

    data_mem_requester #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_load  (start_load),
        .start_store (start_store),
        .cmd_address (cmd_address),
        .cmd_size    (cmd_size),
        .cmd_signed  (cmd_signed),
        .cmd_wdata   (cmd_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .load_data   (load_data),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected outputs per cycle (index = number of rising edges so far).
    bit          e_valid [MAXC];
    bit          e_busy  [MAXC];
    bit          e_done  [MAXC];
    bit          e_err   [MAXC];
    bit          e_rreq  [MAXC];
    bit          e_wreq  [MAXC];
    logic [63:0] e_ld    [MAXC];
    logic [63:0] e_addr  [MAXC];
    logic [1:0]  e_size  [MAXC];
    logic [63:0] e_wdata [MAXC];

    logic [63:0] m_ld = '0;   // model of the held load result

    int rreq_hi = 0, wreq_hi = 0, done_cnt = 0, err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz, input bit sg);
        int          nb;
        logic [63:0] mask, v;
        nb   = 8 << sz;
        mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
        v    = d & mask;
        if (sg && d[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Single compare process.
    always @(negedge clk) begin
        if (cyc < MAXC && e_valid[cyc]) begin
            chk("busy",          busy,                  e_busy[cyc]);
            chk("done",          done,                  e_done[cyc]);
            chk("read_request",  mem_bus.read_request,  e_rreq[cyc]);
            chk("write_request", mem_bus.write_request, e_wreq[cyc]);
            chk("load_data",     load_data,             e_ld[cyc]);
            if (e_done[cyc]) chk("error", error, e_err[cyc]);
            if (e_rreq[cyc] || e_wreq[cyc]) begin
                chk("address",    mem_bus.address,    e_addr[cyc]);
                chk("block_size", mem_bus.block_size, e_size[cyc]);
            end
            if (e_wreq[cyc]) chk("write_data", mem_bus.write_data, e_wdata[cyc]);
        end
    end

    always @(negedge clk) begin
        if (mem_bus.read_request === 1'b1)  rreq_hi++;
        if (mem_bus.write_request === 1'b1) wreq_hi++;
        if (done === 1'b1) begin
            done_cnt++;
            if (error === 1'b1) err_cnt++;
        end
    end

    task automatic zero_counts();
        rreq_hi = 0; wreq_hi = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e_valid[cyc+1] = 1'b1; e_busy[cyc+1] = 1'b0; e_done[cyc+1] = 1'b0;
            e_rreq[cyc+1]  = 1'b0; e_wreq[cyc+1] = 1'b0; e_ld[cyc+1]   = m_ld;
            start_load = 1'b0; start_store = 1'b0;
            mem_bus.read_ready     = ($urandom_range(0, 3) == 0);
            mem_bus.write_ready    = ($urandom_range(0, 3) == 0);
            mem_bus.write_finished = ($urandom_range(0, 3) == 0);
            mem_bus.read_data      = rnd64();
        end
    endtask

    // d1: load -> edge of read_ready; store -> edge of write_ready.
    // d2: store only -> edges from write_ready to write_finished.
    task automatic txn(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input int d1, input int d2, input bit noise, input bit spur_wf);
        int          b, m;
        bit          err, is_ld;
        logic [63:0] ld_after;
        is_ld = ld;
        if (is_ld) begin
            if (d1 <= T1) begin m = d1; err = 1'b0; end
            else          begin m = T1; err = 1'b1; end
        end else begin
            if (d1 > T1)      begin m = T1;      err = 1'b1; end
            else if (d2 > T1) begin m = d1 + T1; err = 1'b1; end
            else              begin m = d1 + d2; err = 1'b0; end
        end
        ld_after = (is_ld && !err) ? ext_model(rdata, sz, sg) : m_ld;

        @(negedge clk);
        b = cyc + 1;
        if (b + m + 2 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d, expected < %0d", b + m + 2, MAXC);
            $fatal(1);
        end
        for (int k = 0; k <= m + 1; k++) begin
            e_valid[b+k] = 1'b1;
            e_busy[b+k]  = (k <= m);
            e_done[b+k]  = (k == m);
            e_err[b+k]   = err;
            e_rreq[b+k]  = is_ld && (k < m);
            e_wreq[b+k]  = !is_ld && (k < m);
            e_ld[b+k]    = (k >= m) ? ld_after : m_ld;
            e_addr[b+k]  = addr;
            e_size[b+k]  = sz;
            e_wdata[b+k] = wdata;
        end
        m_ld = ld_after;

        start_load = ld; start_store = st;
        cmd_address = addr; cmd_size = sz; cmd_signed = sg; cmd_wdata = wdata;
        mem_bus.read_ready = 1'b0; mem_bus.write_ready = 1'b0; mem_bus.write_finished = 1'b0;
        mem_bus.read_data = rnd64();

        for (int e = 1; e <= m + 1; e++) begin
            @(negedge clk);
            start_load  = noise && ($urandom_range(0, 2) == 0);
            start_store = noise && ($urandom_range(0, 2) == 0);
            if (noise) begin
                cmd_address = rnd64(); cmd_size = 2'($urandom_range(0, 3));
                cmd_signed = 1'($urandom_range(0, 1)); cmd_wdata = rnd64();
            end
            mem_bus.read_data = (is_ld && e == d1) ? rdata : rnd64();
            if (is_ld) begin
                mem_bus.read_ready     = (e == d1) || (noise && e > m && $urandom_range(0, 1) == 1);
                mem_bus.write_ready    = noise && ($urandom_range(0, 2) == 0);
                mem_bus.write_finished = noise && ($urandom_range(0, 2) == 0);
            end else begin
                mem_bus.read_ready     = noise && ($urandom_range(0, 2) == 0);
                mem_bus.write_ready    = (e == d1) || (noise && e > d1 && $urandom_range(0, 2) == 0);
                mem_bus.write_finished = (e == d1 + d2) || (spur_wf && e == d1 - 1) ||
                                         (noise && (e <= d1 || e > m) && $urandom_range(0, 2) == 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start_load = 1'b0; start_store = 1'b0; cmd_signed = 1'b0;
        cmd_address = '0; cmd_size = '0; cmd_wdata = '0;
        mem_bus.read_ready = 1'b0; mem_bus.write_ready = 1'b0; mem_bus.write_finished = 1'b0;
        mem_bus.read_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_error", error, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_read_request",  mem_bus.read_request, 0);
        chk("rst_write_request", mem_bus.write_request, 0);
        chk("rst_address",    mem_bus.address, 0);
        chk("rst_block_size", mem_bus.block_size, 0);
        chk("rst_write_data", mem_bus.write_data, 0);
        rst_n = 1'b1;
        idle(2);

        // Signed byte load, read_ready 4 cycles after request.
        zero_counts();
        txn(1, 0, 2'd0, 1, 64'h0000_0000_0000_1000, '0, 64'h0000_0000_0000_00F3, 4, 0, 0, 0);
        idle(2);
        chk("sb_rreq_cycles", rreq_hi, 4);
        chk("sb_done_count",  done_cnt, 1);
        chk("sb_error_count", err_cnt, 0);
        chk("sb_load_data",   load_data, 64'hFFFF_FFFF_FFFF_FFF3);
        chk("sb_model_pin",   m_ld, 64'hFFFF_FFFF_FFFF_FFF3);

        // Double store: write_ready at 3, write_finished 5 later.
        zero_counts();
        txn(0, 1, 2'd3, 0, 64'h0000_0000_0000_2008, 64'hDEAD_BEEF_CAFE_F00D, '0, 3, 5, 0, 0);
        idle(2);
        chk("st_wreq_cycles", wreq_hi, 8);
        chk("st_done_count",  done_cnt, 1);
        chk("st_error_count", err_cnt, 0);

        // Timeout: no read_ready at all.
        zero_counts();
        txn(1, 0, 2'd2, 0, 64'h40, '0, '0, NONE, 0, 0, 0);
        idle(2);
        chk("to_rreq_cycles", rreq_hi, T1);
        chk("to_error_count", err_cnt, 1);
        chk("to_load_data",   load_data, 64'hFFFF_FFFF_FFFF_FFF3);

        // read_ready on the timeout edge wins.
        zero_counts();
        txn(1, 0, 2'd1, 0, 64'h44, '0, 64'h1234_5678_9ABC_8001, T1, 0, 0, 0);
        idle(2);
        chk("tw_error_count", err_cnt, 0);
        chk("tw_done_count",  done_cnt, 1);
        chk("tw_load_data",   load_data, 64'h0000_0000_0000_8001);

        // Both starts: load only.
        zero_counts();
        txn(1, 1, 2'd2, 1, 64'h80, 64'h5555, 64'h0000_0000_8000_0000, 2, 0, 0, 0);
        idle(2);
        chk("both_wreq_cycles", wreq_hi, 0);
        chk("both_rreq_cycles", rreq_hi, 2);
        chk("both_load_data",   load_data, 64'hFFFF_FFFF_8000_0000);

        // Early write_finished ignored; starts while busy ignored.
        zero_counts();
        txn(0, 1, 2'd1, 0, 64'h90, 64'h0BAD, '0, 4, 2, 1, 1);
        idle(2);
        chk("spur_wreq_cycles", wreq_hi, 6);
        chk("spur_done_count",  done_cnt, 1);

        // Reset during WR_WAIT_FINISH.
        idle(1);
        @(negedge clk);
        start_store = 1'b1; cmd_address = 64'hA0; cmd_size = 2'd3; cmd_wdata = 64'h77;
        @(negedge clk);
        start_store = 1'b0; mem_bus.write_ready = 1'b1;
        @(negedge clk);
        mem_bus.write_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_write_request", mem_bus.write_request, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_write_request", mem_bus.write_request, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ld = '0;
        idle(2);
        zero_counts();
        txn(1, 0, 2'd2, 1, 64'hB0, '0, 64'h1111_2222_8765_4321, 1, 0, 0, 0);
        idle(2);
        chk("post_rst_rreq_cycles", rreq_hi, 1);
        chk("post_rst_load_data",   load_data, 64'hFFFF_FFFF_8765_4321);

        // Randomized traffic, back-to-back and with gaps.
        for (int i = 0; i < 200; i++) begin
            int op;
            op = $urandom_range(0, 9);
            txn(op <= 4, op >= 4, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                rnd64(), rnd64(), rnd64(),
                $urandom_range(1, T1 + 2), $urandom_range(1, T1 + 2), 1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
